pll_lock_supervisor: RTL and testbench



---
 rtl/pll_pkg.sv | 14 +
 rtl/sync_ff_chain.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 97 +++++++++
 tb/tb_pll_lock_supervisor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock supervisor and its status-register decode.
package pll_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] WAIT_LOCK  = 2'd0;
    localparam logic [STATE_W-1:0] STABILIZE  = 2'd1;
    localparam logic [STATE_W-1:0] HOLD_RESET = 2'd2;
    localparam logic [STATE_W-1:0] RUNNING    = 2'd3;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RESET_HOLD_CYCLES  = 16;

endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit flip-flop synchroniser chain with synchronous active-low clear.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, sequences the downstream system reset and records lock-loss events.
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int CNT_W              = 8
) (
    input  logic               clock_in,
    input  logic               resetn,
    input  logic               locked_async,
    input  logic               clear_sticky,
    output logic               sys_resetn,
    output logic               ready,
    output logic               lock_lost_sticky,
    output logic [CNT_W-1:0]   lock_loss_count,
    output logic [STATE_W-1:0] state
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

    logic               locked_sync;
    logic [STATE_W-1:0] state_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               loss;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clock_in),
        .resetn (resetn),
        .d      (locked_async),
        .q      (locked_sync)
    );

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        loss    = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_sync) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_sync)            state_d = WAIT_LOCK;
                else if (cnt_q == STAB_LAST) state_d = HOLD_RESET;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            HOLD_RESET: begin
                if (!locked_sync)            state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUNNING;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            RUNNING: begin
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    loss    = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            state            <= WAIT_LOCK;
            cnt_q            <= '0;
            sys_resetn       <= 1'b0;
            ready            <= 1'b0;
            lock_lost_sticky <= 1'b0;
            lock_loss_count  <= '0;
        end else begin
            state      <= state_d;
            cnt_q      <= cnt_d;
            // Decoded from next state so the outputs track the state register with no lag
            sys_resetn <= (state_d == RUNNING);
            ready      <= (state_d == RUNNING);
            if (loss) begin
                lock_lost_sticky <= 1'b1;
                if (clear_sticky)
                    lock_loss_count <= CNT_W'(1);
                else if (lock_loss_count != '1)
                    lock_loss_count <= lock_loss_count + 1'b1;
            end else if (clear_sticky) begin
                lock_lost_sticky <= 1'b0;
                lock_loss_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised and directed bench for pll_lock_supervisor against a run-length reference model.
module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES        = 2;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int RESET_HOLD_CYCLES  = 4;
    localparam int CNT_W              = 2;
    // Consecutive synchronised-high samples the FSM needs before it reports RUNNING
    localparam int RUN_AFTER = 1 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES;
    localparam int RISE_EDGE = 1 + SYNC_STAGES + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clock_in = 1'b0;
    logic             resetn = 1'b0;
    logic             locked_async = 1'b0;
    logic             clear_sticky = 1'b0;
    logic             sys_resetn;
    logic             ready;
    logic             lock_lost_sticky;
    logic [CNT_W-1:0] lock_loss_count;
    logic [1:0]       state;

    int checks = 0;
    int failures = 0;

    int run_len = 0;
    bit pipe[$];
    bit m_sticky = 1'b0;
    int m_count = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .RESET_HOLD_CYCLES  (RESET_HOLD_CYCLES),
        .CNT_W              (CNT_W)
    ) dut (
        .clock_in         (clock_in),
        .resetn           (resetn),
        .locked_async     (locked_async),
        .clear_sticky     (clear_sticky),
        .sys_resetn       (sys_resetn),
        .ready            (ready),
        .lock_lost_sticky (lock_lost_sticky),
        .lock_loss_count  (lock_loss_count),
        .state            (state)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [1:0] exp_state();
        if (run_len == 0) return 2'd0;
        if (run_len <= LOCK_STABLE_CYCLES) return 2'd1;
        if (run_len < RUN_AFTER) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [6:0] exp_vec();
        logic run;
        run = (exp_state() == 2'd3);
        return {run, run, m_sticky, CNT_W'(m_count), exp_state()};
    endfunction

    function automatic logic [6:0] act_vec();
        return {sys_resetn, ready, lock_lost_sticky, lock_loss_count, state};
    endfunction

    // Drive one edge's inputs, advance the reference model, settle 1ns past the edge
    task automatic step(input logic a, input logic clr, input logic rst_n);
        bit seen;
        bit loss;
        locked_async = a;
        clear_sticky = clr;
        resetn       = rst_n;
        @(posedge clock_in);
        if (!rst_n) begin
            pipe = {};
            repeat (SYNC_STAGES) pipe.push_back(1'b0);
            run_len  = 0;
            m_sticky = 1'b0;
            m_count  = 0;
        end else begin
            seen = pipe.pop_front();
            pipe.push_back(a);
            loss = !seen && (run_len >= RUN_AFTER);
            run_len = seen ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
            if (loss) begin
                m_sticky = 1'b1;
                m_count  = clr ? 1 : ((m_count < CNT_MAX) ? m_count + 1 : CNT_MAX);
            end else if (clr) begin
                m_sticky = 1'b0;
                m_count  = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== 7'b0) begin
            failures++;
            $display("FAIL reset_values actual=%b required=%b", act_vec(), 7'b0);
        end
    endtask

    task automatic test_startup();
        int rise_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (sys_resetn === 1'b1 && rise_at < 0) rise_at = k;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL startup edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rise_at != RISE_EDGE) begin
            failures++;
            $display("FAIL startup_rise_edge actual=%0d required=%0d", rise_at, RISE_EDGE);
        end
    endtask

    task automatic test_flicker_stabilize();
        int rise_at = -1;
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 28; k++) begin
            step((k <= 5 || k > 8) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            if (sys_resetn === 1'b1 && rise_at < 0) rise_at = k - 8;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flicker_stab edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rise_at != RISE_EDGE || lock_lost_sticky !== 1'b0 || lock_loss_count !== '0) begin
            failures++;
            $display("FAIL flicker_stab_requal rise=%0d sticky=%b count=%0d required rise=%0d sticky=0 count=0",
                     rise_at, lock_lost_sticky, lock_loss_count, RISE_EDGE);
        end
    endtask

    task automatic test_loss_running();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd3 || sys_resetn !== 1'b1) begin
            failures++;
            $display("FAIL loss_m_plus_1 state=%0d sys_resetn=%b required state=3 sys_resetn=1", state, sys_resetn);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (act_vec() !== {1'b0, 1'b0, 1'b1, 2'd1, 2'd0}) begin
            failures++;
            $display("FAIL loss_m_plus_2 actual=%b required=%b", act_vec(), {1'b0, 1'b0, 1'b1, 2'd1, 2'd0});
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL loss_relock edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation_clear();
        for (int n = 0; n < 5; n++) begin
            repeat (3) step(1'b0, 1'b0, 1'b1);
            for (int k = 1; k <= 16; k++) begin
                step(1'b1, 1'b0, 1'b1);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL saturate cycle=%0d edge=%0d actual=%b required=%b", n, k, act_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (lock_loss_count !== 2'd3 || lock_lost_sticky !== 1'b1) begin
            failures++;
            $display("FAIL saturate_count actual=%0d sticky=%b required=3 sticky=1", lock_loss_count, lock_lost_sticky);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (lock_loss_count !== 2'd0 || lock_lost_sticky !== 1'b0 || state !== 2'd3) begin
            failures++;
            $display("FAIL clear_pulse count=%0d sticky=%b state=%0d required count=0 sticky=0 state=3",
                     lock_loss_count, lock_lost_sticky, state);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (lock_loss_count !== 2'd1 || lock_lost_sticky !== 1'b1 || state !== 2'd0) begin
            failures++;
            $display("FAIL clear_vs_loss count=%0d sticky=%b state=%0d required count=1 sticky=1 state=0",
                     lock_loss_count, lock_lost_sticky, state);
        end
        repeat (16) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL clear_relock actual=%b required=%b", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_running();
        int rise_at = -1;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_run actual=%b required=%b", act_vec(), 7'b0);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (sys_resetn === 1'b1 && rise_at < 0) rise_at = k;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_requal edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rise_at != RISE_EDGE || lock_lost_sticky !== 1'b0 || lock_loss_count !== '0) begin
            failures++;
            $display("FAIL reset_requal_rise rise=%0d sticky=%b count=%0d required rise=%0d sticky=0 count=0",
                     rise_at, lock_lost_sticky, lock_loss_count, RISE_EDGE);
        end
    endtask

    task automatic test_flicker_hold();
        bit rose = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            step((k <= 12) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            if (sys_resetn !== 1'b0) rose = 1'b1;
            if (k == 14) begin
                checks++;
                if (state !== 2'd2) begin
                    failures++;
                    $display("FAIL flicker_hold_in_hold state=%0d required=2", state);
                end
            end
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flicker_hold edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rose || state !== 2'd0 || lock_lost_sticky !== 1'b0 || lock_loss_count !== '0) begin
            failures++;
            $display("FAIL flicker_hold_end rose=%b state=%0d sticky=%b count=%0d required rose=0 state=0 sticky=0 count=0",
                     rose, state, lock_lost_sticky, lock_loss_count);
        end
    endtask

    task automatic test_random();
        logic a = 1'b0;
        int seg = 0;
        for (int k = 0; k < 3000; k++) begin
            if (seg == 0) begin
                a   = ~a;
                seg = a ? $urandom_range(1, 30) : $urandom_range(1, 6);
            end
            seg--;
            step(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random edge=%0d actual=%b required=%b", k, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_flicker_stabilize();
        test_loss_running();
        test_saturation_clear();
        test_reset_running();
        test_flicker_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
